// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions used by the read-modify-write sequencer.
//
// Contents:
//   ALU_* constants   - opcode encoding on the ALU op bus
//   rmw_op_e          - memory RMW operation selected by the decoder
//   rmw_state_e       - RMW sequencer FSM states
//   alu_ctl_t         - ALU op / operand B / carry-in bundle
//   rmw_op_valid()    - true for the six implemented RMW operations
//   rmw_is_shift()    - true for ASL/LSR/ROL/ROR (those update P.C)
//   rmw_alu_map()     - RMW operation to ALU control mapping
package cpu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SHR = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;

    typedef enum logic [2:0] {
        RMW_ASL = 3'd0,
        RMW_LSR = 3'd1,
        RMW_ROL = 3'd2,
        RMW_ROR = 3'd3,
        RMW_INC = 3'd4,
        RMW_DEC = 3'd5
    } rmw_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        DUMMY_WR = 2'd2,
        WRITE    = 2'd3
    } rmw_state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] b;
        logic       cin;
    } alu_ctl_t;

    function automatic logic rmw_op_valid(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    function automatic logic rmw_is_shift(input rmw_op_e op);
        return (op == RMW_ASL) || (op == RMW_LSR) ||
               (op == RMW_ROL) || (op == RMW_ROR);
    endfunction

    // Rotates feed the latched carry into the vacated bit; plain shifts feed 0.
    // DEC uses cin=1 because the ALU subtract computes a - b - !cin.
    function automatic alu_ctl_t rmw_alu_map(input rmw_op_e op, input logic c);
        alu_ctl_t ctl;
        ctl = '{op: ALU_ADD, b: 8'h00, cin: 1'b0};
        case (op)
            RMW_ASL: ctl = '{op: ALU_SHL, b: 8'h00, cin: 1'b0};
            RMW_ROL: ctl = '{op: ALU_SHL, b: 8'h00, cin: c};
            RMW_LSR: ctl = '{op: ALU_SHR, b: 8'h00, cin: 1'b0};
            RMW_ROR: ctl = '{op: ALU_SHR, b: 8'h00, cin: c};
            RMW_INC: ctl = '{op: ALU_ADD, b: 8'h01, cin: 1'b0};
            RMW_DEC: ctl = '{op: ALU_SUB, b: 8'h01, cin: 1'b1};
            default: ctl = '{op: ALU_ADD, b: 8'h00, cin: 1'b0};
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/cpu_rmw_seq.sv
// Read-modify-write sequencer for the 2A03 CPU core (ALU initiator side).
// Runs the memory phases of ASL/LSR/ROL/ROR/INC/DEC on a memory operand:
// read, dummy write of the original value, write of the modified value.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, op_addr, rmw_op     request from the decoder (sampled when idle)
//   carry_flag                 current P.C, sampled with start
//   bus_addr/we/wdata          bus request, all registered
//   bus_rdata, bus_rdy         read data and RDY (stalls reads only)
//   alu_a/b/op/cin             ALU operands and op, held outside DUMMY_WR
//   alu_out, alu_carry         combinational ALU result
//   busy, done                 not-idle indicator, final-write pulse
//   flag_n/z/c, flag_c_we      result flags for the status register
//
// Only DATA_W=8 is supported; the ALU interface is fixed at 8 bits.
module cpu_rmw_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [2:0]        rmw_op,
    input  logic              carry_flag,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rdy,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_cin,
    input  logic [7:0]        alu_out,
    input  logic              alu_carry,
    output logic              busy,
    output logic              done,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_c_we
);

    rmw_state_e state;
    rmw_op_e    lat_op;
    logic       lat_c;
    logic [7:0] tmp;
    logic [7:0] res;
    logic       cres;
    alu_ctl_t   ctl;

    // ALU control is a pure function of the latched request; it is loaded
    // into the alu_* registers on entry to DUMMY_WR so the ALU settles there.
    assign ctl   = rmw_alu_map(lat_op, lat_c);
    assign alu_a = tmp;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_op    <= RMW_ASL;
            lat_c     <= 1'b0;
            tmp       <= 8'h00;
            res       <= 8'h00;
            cres      <= 1'b0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
            alu_b     <= 8'h00;
            alu_op    <= ALU_ADD;
            alu_cin   <= 1'b0;
            done      <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_c_we <= 1'b0;
        end else begin
            done      <= 1'b0;
            flag_c_we <= 1'b0;
            case (state)
                IDLE: begin
                    bus_we <= 1'b0;
                    // Reserved opcodes are dropped here rather than run as a no-op.
                    if (start && rmw_op_valid(rmw_op)) begin
                        lat_op   <= rmw_op_e'(rmw_op);
                        lat_c    <= carry_flag;
                        bus_addr <= op_addr;
                        state    <= READ;
                    end
                end
                READ: begin
                    bus_we <= 1'b0;
                    if (bus_rdy) begin
                        tmp       <= bus_rdata[7:0];
                        bus_we    <= 1'b1;
                        bus_wdata <= bus_rdata;
                        alu_b     <= ctl.b;
                        alu_op    <= ctl.op;
                        alu_cin   <= ctl.cin;
                        state     <= DUMMY_WR;
                    end
                end
                DUMMY_WR: begin
                    // Writes never stall, so bus_rdy is not consulted here.
                    res       <= alu_out;
                    cres      <= alu_carry;
                    bus_wdata <= alu_out;
                    done      <= 1'b1;
                    flag_n    <= alu_out[7];
                    flag_z    <= (alu_out == 8'h00);
                    flag_c    <= alu_carry;
                    flag_c_we <= rmw_is_shift(lat_op);
                    state     <= WRITE;
                end
                WRITE: begin
                    bus_we <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    bus_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // res/cres keep the last result for debug visibility only.
    logic unused_res;
    assign unused_res = ^{res, cres};

endmodule

// File: tb/tb_cpu_rmw_seq.sv
// Directed bench for cpu_rmw_seq with a behavioural 6502-style ALU model.
module tb_cpu_rmw_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_addr;
    logic [2:0]  rmw_op;
    logic        carry_flag;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rdy;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        busy;
    logic        done;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_c_we;

    int vectors = 0;
    int miscompares = 0;

    cpu_rmw_seq #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_addr(op_addr),
        .rmw_op(rmw_op), .carry_flag(carry_flag), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_rdy(bus_rdy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_out(alu_out), .alu_carry(alu_carry),
        .busy(busy), .done(done), .flag_n(flag_n), .flag_z(flag_z),
        .flag_c(flag_c), .flag_c_we(flag_c_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: add/sub with 6502 carry semantics (C = no borrow), shifts via cin.
    logic [8:0] alu_t;
    always_comb begin
        alu_t     = 9'd0;
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_t     = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
                alu_out   = alu_t[7:0];
                alu_carry = alu_t[8];
            end
            3'd1: begin
                alu_t     = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, ~alu_cin};
                alu_out   = alu_t[7:0];
                alu_carry = ~alu_t[8];
            end
            3'd5: begin
                alu_out   = {alu_cin, alu_a[7:1]};
                alu_carry = alu_a[0];
            end
            3'd6: begin
                alu_out   = {alu_a[6:0], alu_cin};
                alu_carry = alu_a[7];
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete RMW transaction, checked cycle by cycle.
    // stall: number of READ cycles with bus_rdy=0 before the data is taken.
    // poke:  also pulse a valid start during DUMMY_WR and WRITE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [2:0] op,
                          input logic c, input logic [7:0] rd, input int stall,
                          input logic [7:0] res, input logic n, input logic z,
                          input logic cf, input logic cwe, input logic poke);
        op_addr    = a;
        rmw_op     = op;
        carry_flag = c;
        start      = 1'b1;
        bus_rdy    = (stall == 0);
        bus_rdata  = (stall == 0) ? rd : 8'hEE;
        tick();
        // Disturb the request inputs; the sequencer must use the latched copies.
        start      = 1'b0;
        carry_flag = ~c;
        rmw_op     = 3'd0;
        op_addr    = ~a;
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) begin
                bus_rdy   = 1'b1;
                bus_rdata = rd;
            end
            chk({tag, ".rd_busy"}, busy, 1);
            chk({tag, ".rd_addr"}, bus_addr, a);
            chk({tag, ".rd_we"}, bus_we, 0);
            chk({tag, ".rd_done"}, done, 0);
            tick();
        end
        bus_rdy   = 1'b0;
        bus_rdata = 8'h5A;
        if (poke) start = 1'b1;
        chk({tag, ".dw_we"}, bus_we, 1);
        chk({tag, ".dw_addr"}, bus_addr, a);
        chk({tag, ".dw_data"}, bus_wdata, rd);
        chk({tag, ".dw_done"}, done, 0);
        tick();
        chk({tag, ".wr_we"}, bus_we, 1);
        chk({tag, ".wr_addr"}, bus_addr, a);
        chk({tag, ".wr_data"}, bus_wdata, res);
        chk({tag, ".wr_done"}, done, 1);
        chk({tag, ".wr_busy"}, busy, 1);
        chk({tag, ".flag_n"}, flag_n, n);
        chk({tag, ".flag_z"}, flag_z, z);
        if (cwe) chk({tag, ".flag_c"}, flag_c, cf);
        chk({tag, ".flag_c_we"}, flag_c_we, cwe);
        tick();
        start = 1'b0;
        chk({tag, ".end_busy"}, busy, 0);
        chk({tag, ".end_we"}, bus_we, 0);
        chk({tag, ".end_done"}, done, 0);
        chk({tag, ".end_cwe"}, flag_c_we, 0);
        tick();
        chk({tag, ".idle_busy"}, busy, 0);
        chk({tag, ".idle_we"}, bus_we, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        op_addr    = 16'h0000;
        rmw_op     = 3'd0;
        carry_flag = 1'b0;
        bus_rdata  = 8'h00;
        bus_rdy    = 1'b1;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.we", bus_we, 0);
        chk("rst.done", done, 0);
        chk("rst.addr", bus_addr, 0);
        chk("rst.wdata", bus_wdata, 0);
        chk("rst.alu_a", alu_a, 0);
        chk("rst.alu_b", alu_b, 0);
        chk("rst.flags", {flag_n, flag_z, flag_c, flag_c_we}, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        //      tag    addr      op  C  rd     stall res    N  Z  C  cwe poke
        run_op("asl", 16'h0200, 0, 0, 8'h81, 0, 8'h02, 0, 0, 1, 1, 0);
        run_op("ror", 16'h0201, 3, 1, 8'h01, 0, 8'h80, 1, 0, 1, 1, 0);
        run_op("inc", 16'h0010, 4, 0, 8'hFF, 0, 8'h00, 0, 1, 0, 0, 0);
        run_op("dec", 16'h0011, 5, 0, 8'h00, 0, 8'hFF, 1, 0, 0, 0, 0);
        run_op("rol", 16'h1234, 2, 1, 8'h80, 0, 8'h01, 0, 0, 1, 1, 0);
        run_op("lsr", 16'hFFFF, 1, 1, 8'h01, 0, 8'h00, 0, 1, 1, 1, 0);
        run_op("stall", 16'h0300, 0, 0, 8'h40, 3, 8'h80, 1, 0, 0, 1, 0);
        run_op("poke", 16'h0400, 4, 1, 8'h7F, 0, 8'h80, 1, 0, 0, 0, 1);

        // Reserved opcode: start must be ignored entirely.
        op_addr = 16'h0500;
        rmw_op  = 3'd7;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("rsv.busy", busy, 0);
        chk("rsv.we", bus_we, 0);
        tick();
        chk("rsv.busy2", busy, 0);
        chk("rsv.addr", bus_addr, 16'h0400);

        // Reset asserted during DUMMY_WR aborts the write with no clock edge.
        op_addr   = 16'h0600;
        rmw_op    = 3'd4;
        bus_rdy   = 1'b1;
        bus_rdata = 8'h10;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort.pre_we", bus_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.we", bus_we, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        tick();
        chk("abort.done2", done, 0);
        chk("abort.busy2", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after", 16'h0600, 4, 0, 8'h10, 0, 8'h11, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
